// File: rtl/multicycle_datapath_pkg.sv
// Shared definitions for the multicycle RV32 subset core: opcodes, function codes,
// ALU operation encoding, immediate formats and control FSM states.
package multicycle_datapath_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
    } alu_op_e;

    typedef enum logic [1:0] {
        IMM_I, IMM_S, IMM_B
    } imm_sel_e;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_e;

endpackage

// File: rtl/multicycle_datapath_alu.sv
// XLEN-wide ALU shared with the single-cycle datapath; zero flag feeds branch compare.
module multicycle_datapath_alu
    import multicycle_datapath_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_e          op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    output logic [XLEN-1:0]  y,
    output logic             zero
);

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SLT: y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            default: y = '0;
        endcase
        zero = (y == '0);
    end

endmodule

// File: rtl/multicycle_datapath_imm_gen.sv
// I/S/B immediate extraction, sign-extended to XLEN.
module multicycle_datapath_imm_gen
    import multicycle_datapath_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]      instr,
    input  imm_sel_e         sel,
    output logic [XLEN-1:0]  imm
);

    // rs1/funct3 and opcode fields never carry immediate bits in these formats
    logic unused_bits;
    assign unused_bits = ^{instr[19:12], instr[6:0]};

    always_comb begin
        imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
        case (sel)
            IMM_S:   imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            default: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
        endcase
    end

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle RV32 subset core: FETCH/DECODE/EXEC/MEM/WB control with req/ready
// instruction and data ports; halts sticky on any unsupported instruction.
module multicycle_datapath
    import multicycle_datapath_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter int              NREGS      = 32,
    parameter logic [XLEN-1:0] INITIAL_PC = XLEN'(32'h00400000)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [XLEN-1:0]  dmem_addr,
    output logic [XLEN-1:0]  dmem_wdata,
    input  logic             dmem_ready,
    input  logic [XLEN-1:0]  dmem_rdata,
    output logic [XLEN-1:0]  PC,
    output logic             retire,
    output logic             illegal
);

    localparam int              RIDX    = $clog2(NREGS);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d, a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [XLEN-1:0]   target_q, target_d, aluout_q, aluout_d, mdr_q, mdr_d;
    logic [31:0]       ir_q, ir_d;
    logic              illegal_q, illegal_d;
    logic [XLEN-1:0]   regs_q [NREGS];
    logic [XLEN-1:0]   regs_d [NREGS];

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rd, rs1, rs2;
    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];

    function automatic logic idx_ok(input logic [4:0] idx);
        return {27'd0, idx} < 32'(NREGS);
    endfunction

    logic     op_ok, legal, use_imm, is_branch, is_load, is_store, writes_rd, uses_rs2;
    alu_op_e  alu_op;
    imm_sel_e imm_sel;

    always_comb begin
        op_ok = 1'b0; use_imm = 1'b0; is_branch = 1'b0; is_load = 1'b0; is_store = 1'b0;
        writes_rd = 1'b0; uses_rs2 = 1'b0; alu_op = ALU_ADD; imm_sel = IMM_I;
        case (opcode)
            OP_R: begin
                writes_rd = 1'b1;
                uses_rs2  = 1'b1;
                if (funct7 == F7_BASE) begin
                    op_ok = 1'b1;
                    case (funct3)
                        F3_ADD:  alu_op = ALU_ADD;
                        F3_SLT:  alu_op = ALU_SLT;
                        F3_OR:   alu_op = ALU_OR;
                        F3_AND:  alu_op = ALU_AND;
                        default: op_ok = 1'b0;
                    endcase
                end else if (funct7 == F7_SUB && funct3 == F3_ADD) begin
                    op_ok  = 1'b1;
                    alu_op = ALU_SUB;
                end
            end
            OP_I: begin
                writes_rd = 1'b1;
                use_imm   = 1'b1;
                op_ok     = 1'b1;
                case (funct3)
                    F3_ADD:  alu_op = ALU_ADD;
                    F3_SLT:  alu_op = ALU_SLT;
                    F3_OR:   alu_op = ALU_OR;
                    F3_AND:  alu_op = ALU_AND;
                    default: op_ok = 1'b0;
                endcase
            end
            OP_LOAD: begin
                is_load = 1'b1; writes_rd = 1'b1; use_imm = 1'b1;
                op_ok   = (funct3 == F3_LW);
            end
            OP_STORE: begin
                is_store = 1'b1; uses_rs2 = 1'b1; use_imm = 1'b1; imm_sel = IMM_S;
                op_ok    = (funct3 == F3_SW);
            end
            OP_BRANCH: begin
                is_branch = 1'b1; uses_rs2 = 1'b1; imm_sel = IMM_B; alu_op = ALU_SUB;
                op_ok     = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
            end
            default: op_ok = 1'b0;
        endcase
        legal = op_ok && idx_ok(rs1) && (!uses_rs2 || idx_ok(rs2)) && (!writes_rd || idx_ok(rd));
    end

    logic [XLEN-1:0] imm_val, alu_y;
    logic            alu_zero;

    multicycle_datapath_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (ir_q),
        .sel   (imm_sel),
        .imm   (imm_val)
    );

    multicycle_datapath_alu #(.XLEN(XLEN)) u_alu (
        .op   (alu_op),
        .a    (a_q),
        .b    (use_imm ? imm_q : b_q),
        .y    (alu_y),
        .zero (alu_zero)
    );

    logic imem_req_c, dmem_req_c, retire_c;

    always_comb begin
        state_d = state_q; pc_d = pc_q; ir_d = ir_q; a_d = a_q; b_d = b_q; imm_d = imm_q;
        target_d = target_q; aluout_d = aluout_q; mdr_d = mdr_q; illegal_d = illegal_q;
        regs_d = regs_q;
        imem_req_c = 1'b0; dmem_req_c = 1'b0; retire_c = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d      = regs_q[rs1[RIDX-1:0]];
                b_d      = regs_q[rs2[RIDX-1:0]];
                imm_d    = imm_val;
                target_d = pc_q + imm_val;
                if (legal) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_EXEC: begin
                aluout_d = alu_y;
                if (is_branch) begin
                    // funct3[0] distinguishes BNE from BEQ
                    pc_d     = (alu_zero ^ funct3[0]) ? target_q : pc_q + PC_STEP;
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                if (dmem_ready) begin
                    if (is_store) begin
                        pc_d     = pc_q + PC_STEP;
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        mdr_d   = dmem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                if (rd != 5'd0) regs_d[rd[RIDX-1:0]] = is_load ? mdr_q : aluout_q;
                pc_d     = pc_q + PC_STEP;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            pc_q      <= INITIAL_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            target_q  <= '0;
            aluout_q  <= '0;
            mdr_q     <= '0;
            illegal_q <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            imm_q     <= imm_d;
            target_q  <= target_d;
            aluout_q  <= aluout_d;
            mdr_q     <= mdr_d;
            illegal_q <= illegal_d;
            regs_q    <= regs_d;
        end
    end

    // Requests drop the moment reset asserts, even though reset forces FETCH.
    assign imem_req   = imem_req_c & rst;
    assign dmem_req   = dmem_req_c & rst;
    assign imem_addr  = pc_q;
    assign dmem_we    = is_store && (state_q == S_MEM);
    assign dmem_addr  = aluout_q;
    assign dmem_wdata = b_q;
    assign PC         = pc_q;
    assign retire     = retire_c;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed program run against a req/ready memory model with programmable wait-states.
module tb_multicycle_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, retire, illegal;
    logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, PC;

    always #5 clk = ~clk;

    logic [31:0] imem [0:63];
    logic [31:0] dmem [0:63];
    int ilat = 0, dlat = 0, icnt = 0, dcnt = 0;
    int checks = 0, failures = 0;

    assign imem_ready = imem_req && (icnt >= ilat);
    assign imem_rdata = imem[imem_addr[7:2]];
    assign dmem_ready = dmem_req && (dcnt >= dlat);
    assign dmem_rdata = dmem[dmem_addr[7:2]];

    always @(posedge clk) begin
        icnt <= (imem_req && !imem_ready) ? icnt + 1 : 0;
        dcnt <= (dmem_req && !dmem_ready) ? dcnt + 1 : 0;
        if (dmem_req && dmem_ready && dmem_we) dmem[dmem_addr[7:2]] <= dmem_wdata;
    end

    multicycle_datapath dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .PC(PC), .retire(retire), .illegal(illegal)
    );

    // Data-port stability while waiting, plus a retire pulse count
    logic        p_wait = 1'b0, p_we = 1'b0;
    logic [31:0] p_addr = '0, p_wdata = '0;
    int          unstable = 0, n_retire = 0;
    always @(negedge clk) begin
        if (p_wait && (!dmem_req || dmem_addr !== p_addr || dmem_wdata !== p_wdata || dmem_we !== p_we))
            unstable <= unstable + 1;
        p_wait  <= rst && dmem_req && !dmem_ready;
        p_addr  <= dmem_addr;
        p_wdata <= dmem_wdata;
        p_we    <= dmem_we;
        if (rst && retire) n_retire <= n_retire + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_lw(input logic [11:0] imm, input logic [4:0] rs1, input logic [4:0] rd);
        return {imm, rs1, 3'b010, rd, 7'b0000011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    // Entered at the negedge of an instruction's first FETCH cycle; leaves at the next one.
    task automatic step(input string tag, input int il, input int dl, input int ecyc, input logic [31:0] epc);
        int cnt;
        ilat = il;
        dlat = dl;
        cnt  = 1;
        while (!retire && cnt < 60) begin
            @(negedge clk);
            cnt++;
        end
        chk({tag, "_retire"}, 32'(retire), 32'd1);
        chk({tag, "_cycles"}, cnt, ecyc);
        @(negedge clk);
        chk({tag, "_pc"}, PC, epc);
    endtask

    localparam logic [31:0] BASE = 32'h00400000;
    localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

    initial begin
        int bad, cnt;
        for (int i = 0; i < 64; i++) begin
            imem[i] = 32'hFFFF_FFFF;
            dmem[i] = '0;
        end
        dmem[6]  = DEAD;
        dmem[13] = DEAD;
        imem[0]  = enc_i(12'd5, 5'd0, 3'b000, 5'd1);            // ADDI x1,x0,5
        imem[1]  = enc_i(12'hFFD, 5'd0, 3'b000, 5'd2);          // ADDI x2,x0,-3
        imem[2]  = enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd3);      // SLT x3,x2,x1
        imem[3]  = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4);      // SUB x4,x1,x2
        imem[4]  = enc_s(12'd8, 5'd1, 5'd0);                    // SW x1,8(x0)
        imem[5]  = enc_lw(12'd8, 5'd0, 5'd5);                   // LW x5,8(x0)
        imem[6]  = enc_i(12'h0F0, 5'd2, 3'b111, 5'd8);          // ANDI x8,x2,0xF0
        imem[7]  = enc_i(12'h100, 5'd1, 3'b110, 5'd9);          // ORI x9,x1,0x100
        imem[8]  = enc_r(7'h00, 5'd1, 5'd2, 3'b111, 5'd10);     // AND x10,x2,x1
        imem[9]  = enc_r(7'h00, 5'd4, 5'd1, 3'b110, 5'd11);     // OR x11,x1,x4
        imem[10] = enc_i(12'hFFF, 5'd1, 3'b010, 5'd12);         // SLTI x12,x1,-1
        imem[11] = enc_i(12'd0, 5'd2, 3'b010, 5'd13);           // SLTI x13,x2,0
        imem[12] = enc_i(12'd7, 5'd0, 3'b000, 5'd0);            // ADDI x0,x0,7
        imem[13] = enc_b(13'd16, 5'd1, 5'd1, 3'b001);           // BNE x1,x1,+16
        imem[14] = enc_b(13'd8, 5'd1, 5'd1, 3'b000);            // BEQ x1,x1,+8
        imem[15] = enc_i(12'd99, 5'd0, 3'b000, 5'd6);           // ADDI x6,x0,99 (skipped)
        imem[16] = enc_i(12'd1, 5'd6, 3'b000, 5'd6);            // ADDI x6,x6,1
        imem[17] = enc_i(12'd2, 5'd0, 3'b000, 5'd7);            // ADDI x7,x0,2
        imem[18] = enc_b(13'h1FF8, 5'd7, 5'd6, 3'b001);         // BNE x6,x7,-8
        imem[19] = enc_s(12'd12, 5'd3, 5'd0);
        imem[20] = enc_s(12'd16, 5'd4, 5'd0);
        imem[21] = enc_s(12'd20, 5'd5, 5'd0);
        imem[22] = enc_s(12'd24, 5'd0, 5'd0);
        imem[23] = enc_s(12'd28, 5'd6, 5'd0);
        imem[24] = enc_s(12'd32, 5'd2, 5'd0);
        imem[25] = enc_s(12'd36, 5'd8, 5'd0);
        imem[26] = enc_s(12'd40, 5'd9, 5'd0);
        imem[27] = enc_s(12'd44, 5'd10, 5'd0);
        imem[28] = enc_s(12'd48, 5'd11, 5'd0);
        imem[29] = enc_s(12'd52, 5'd12, 5'd0);
        imem[30] = enc_s(12'd56, 5'd13, 5'd0);                  // word 31 stays 0xFFFFFFFF

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_retire", 32'(retire), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_pc", PC, BASE);
        rst = 1'b1;
        #1;
        chk("fetch_req", 32'(imem_req), 32'd1);
        chk("fetch_addr", imem_addr, BASE);

        step("addi_x1", 0, 0, 4, BASE + 32'h04);
        step("addi_x2", 0, 0, 4, BASE + 32'h08);
        step("slt", 0, 0, 4, BASE + 32'h0C);
        step("sub_iwait", 2, 0, 6, BASE + 32'h10);
        step("sw_wait", 0, 3, 7, BASE + 32'h14);
        step("lw_wait", 0, 3, 8, BASE + 32'h18);
        step("andi", 0, 0, 4, BASE + 32'h1C);
        step("ori", 0, 0, 4, BASE + 32'h20);
        step("and", 0, 0, 4, BASE + 32'h24);
        step("or", 0, 0, 4, BASE + 32'h28);
        step("slti_a", 0, 0, 4, BASE + 32'h2C);
        step("slti_b", 0, 0, 4, BASE + 32'h30);
        step("addi_x0", 0, 0, 4, BASE + 32'h34);
        step("bne_nt", 0, 0, 3, BASE + 32'h38);
        step("beq_t", 0, 0, 3, BASE + 32'h40);
        step("inc1", 0, 0, 4, BASE + 32'h44);
        step("li2_1", 0, 0, 4, BASE + 32'h48);
        step("bne_back", 0, 0, 3, BASE + 32'h40);
        step("inc2", 0, 0, 4, BASE + 32'h44);
        step("li2_2", 0, 0, 4, BASE + 32'h48);
        step("bne_fall", 0, 0, 3, BASE + 32'h4C);
        for (int i = 19; i <= 30; i++) step("sw_dump", 0, 0, 4, BASE + 32'(i * 4 + 4));

        chk("mem_sw_x1", dmem[2], 32'd5);
        chk("mem_slt", dmem[3], 32'd1);
        chk("mem_sub", dmem[4], 32'd8);
        chk("mem_lw", dmem[5], 32'd5);
        chk("mem_x0", dmem[6], 32'd0);
        chk("mem_rd_eq_rs1", dmem[7], 32'd2);
        chk("mem_neg", dmem[8], 32'hFFFF_FFFD);
        chk("mem_andi", dmem[9], 32'h0000_00F0);
        chk("mem_ori", dmem[10], 32'h0000_0105);
        chk("mem_and", dmem[11], 32'd5);
        chk("mem_or", dmem[12], 32'h0000_000D);
        chk("mem_slti_a", dmem[13], 32'd0);
        chk("mem_slti_b", dmem[14], 32'd1);
        chk("dmem_stable", 32'(unstable), 32'd0);

        // illegal word at BASE+0x7C; currently in its FETCH cycle with ready
        @(negedge clk);
        @(negedge clk);
        chk("illegal_set", 32'(illegal), 32'd1);
        chk("halt_no_req", 32'(imem_req), 32'd0);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (imem_req || dmem_req || retire || PC !== BASE + 32'h7C || !illegal) bad++;
        end
        chk("halt_quiet", 32'(bad), 32'd0);
        chk("halt_pc", PC, BASE + 32'h7C);
        #1;
        chk("retire_total", 32'(n_retire), 32'd33);

        rst = 1'b0;
        imem[0]  = enc_i(12'd9, 5'd0, 3'b000, 5'd1);            // ADDI x1,x0,9
        imem[1]  = enc_s(12'd64, 5'd1, 5'd0);                   // SW x1,64(x0)
        dmem[16] = DEAD;
        dmem[17] = DEAD;
        #1;
        chk("rst_clr_illegal", 32'(illegal), 32'd0);
        chk("rst_clr_pc", PC, BASE);
        @(negedge clk);
        rst = 1'b1;
        step("rst_addi", 0, 20, 4, BASE + 32'h04);
        cnt = 0;
        while (!dmem_req && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        chk("mid_mem_req", 32'(dmem_req), 32'd1);
        chk("mid_mem_addr", dmem_addr, 32'd64);
        chk("mid_mem_wdata", dmem_wdata, 32'd9);
        rst = 1'b0;
        #1;
        chk("abort_dmem_req", 32'(dmem_req), 32'd0);
        chk("abort_imem_req", 32'(imem_req), 32'd0);
        chk("abort_pc", PC, BASE);
        imem[0] = enc_s(12'd68, 5'd1, 5'd0);                    // SW x1,68(x0)
        @(negedge clk);
        rst = 1'b1;
        step("post_rst_sw", 0, 0, 4, BASE + 32'h04);
        chk("abandoned_store", dmem[16], DEAD);
        chk("regs_cleared", dmem[17], 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
